// File: rtl/riscv_defs.sv
// -----------------------------------------------------------------------------
// riscv_defs
// Shared definitions for the RV32IM execute stage: datapath width, ALU
// operation codes, result-source selects and the divider FSM state type.
// -----------------------------------------------------------------------------
package riscv_defs;

  localparam int XLEN = 32;

  // Operation codes carried on aluop.
  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_SLL    = 5'h02;
  localparam logic [4:0] ALU_SLT    = 5'h03;
  localparam logic [4:0] ALU_SLTU   = 5'h04;
  localparam logic [4:0] ALU_XOR    = 5'h05;
  localparam logic [4:0] ALU_SRL    = 5'h06;
  localparam logic [4:0] ALU_SRA    = 5'h07;
  localparam logic [4:0] ALU_OR     = 5'h08;
  localparam logic [4:0] ALU_AND    = 5'h09;
  localparam logic [4:0] ALU_MUL    = 5'h0A;
  localparam logic [4:0] ALU_MULH   = 5'h0B;
  localparam logic [4:0] ALU_MULHSU = 5'h0C;
  localparam logic [4:0] ALU_MULHU  = 5'h0D;
  localparam logic [4:0] ALU_DIV    = 5'h0E;
  localparam logic [4:0] ALU_DIVU   = 5'h0F;
  localparam logic [4:0] ALU_REM    = 5'h10;
  localparam logic [4:0] ALU_REMU   = 5'h11;
  localparam logic [4:0] ALU_JAL    = 5'h12;
  localparam logic [4:0] ALU_LUI    = 5'h13;
  localparam logic [4:0] ALU_LOAD   = 5'h14;
  localparam logic [4:0] ALU_STORE  = 5'h15;

  // Result-source selects carried on alusel.
  localparam logic [2:0] SEL_NONE  = 3'b000;
  localparam logic [2:0] SEL_ARITH = 3'b001;
  localparam logic [2:0] SEL_MUL   = 3'b010;
  localparam logic [2:0] SEL_DIV   = 3'b011;
  localparam logic [2:0] SEL_LINK  = 3'b100;
  localparam logic [2:0] SEL_LDST  = 3'b101;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_div.sv
// -----------------------------------------------------------------------------
// ex_div
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. One quotient bit
// per cycle over DIV_CYCLES steps, operating on latched magnitudes with the
// result signs recorded at start. Divide-by-zero and signed overflow are
// answered combinationally without entering the FSM.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (aborts a division)
//   start_i        a div/rem op is present this cycle
//   signed_op_i    DIV/REM (1) versus DIVU/REMU (0)
//   rem_sel_i      return remainder (1) or quotient (0)
//   dividend_i     dividend, sampled only when the FSM leaves IDLE
//   divisor_i      divisor, sampled only when the FSM leaves IDLE
//   hold_i         EX held downstream: delays start and holds a finished result
//   result_o       bypass result (IDLE) or corrected result (DONE), else 0
//   busy_o         stall request while the result is not yet available
// -----------------------------------------------------------------------------
module ex_div #(
  parameter int XLEN       = riscv_defs::XLEN,
  parameter int DIV_CYCLES = riscv_defs::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            signed_op_i,
  input  logic            rem_sel_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            hold_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  import riscv_defs::*;

  localparam int               CNT_W     = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quot_q, quot_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             rem_sel_q, rem_sel_d;

  // Operand classification on the live inputs (used only in IDLE).
  logic            div_by_zero, overflow;
  logic            dividend_neg, divisor_neg;
  logic [XLEN-1:0] dividend_abs, divisor_abs;

  assign div_by_zero  = (divisor_i == '0);
  assign overflow     = signed_op_i && (dividend_i == MOST_NEG) && (divisor_i == '1);
  assign dividend_neg = signed_op_i & dividend_i[XLEN-1];
  assign divisor_neg  = signed_op_i & divisor_i[XLEN-1];
  assign dividend_abs = dividend_neg ? -dividend_i : dividend_i;
  assign divisor_abs  = divisor_neg  ? -divisor_i  : divisor_i;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor. The partial remainder stays below the
  // divisor, so the shifted value fits XLEN+1 bits and the top bit of the
  // difference is a reliable sign.
  logic [XLEN:0] rem_shift, rem_diff;
  logic          step_ge;

  assign rem_shift = {rem_q, quot_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};
  assign step_ge   = ~rem_diff[XLEN];

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    rem_sel_d  = rem_sel_q;
    busy_o     = 1'b0;
    result_o   = '0;

    unique case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          if (div_by_zero) begin
            result_o = rem_sel_i ? dividend_i : '1;
          end else if (overflow) begin
            // Quotient of MOST_NEG / -1 is MOST_NEG itself, i.e. the dividend.
            result_o = rem_sel_i ? '0 : dividend_i;
          end else begin
            busy_o = 1'b1;
            if (!hold_i) begin
              state_d    = DIV_BUSY;
              cnt_d      = '0;
              rem_d      = '0;
              quot_d     = dividend_abs;
              dvsr_d     = divisor_abs;
              neg_quot_d = dividend_neg ^ divisor_neg;
              neg_rem_d  = dividend_neg;
              rem_sel_d  = rem_sel_i;
            end
          end
        end
      end

      DIV_BUSY: begin
        busy_o = 1'b1;
        rem_d  = step_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], step_ge};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = DIV_DONE;
        end
      end

      DIV_DONE: begin
        if (rem_sel_q) begin
          result_o = neg_rem_q ? -rem_q : rem_q;
        end else begin
          result_o = neg_quot_q ? -quot_q : quot_q;
        end
        if (!hold_i) begin
          state_d = DIV_IDLE;
        end
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge next-state value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the datapath registers carry no reset; they are always loaded on
  // the IDLE->BUSY transition before anything reads them.
  always_ff @(posedge clk) begin
    rem_q      <= rem_d;
    quot_q     <= quot_d;
    dvsr_q     <= dvsr_d;
    neg_quot_q <= neg_quot_d;
    neg_rem_q  <= neg_rem_d;
    rem_sel_q  <= rem_sel_d;
  end

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage RV32IM pipeline. Single-cycle ALU, shifter and
// 64-bit multiplier feed a result mux selected by alusel; divide/remainder
// ops go through the iterative ex_div, which raises stallreq while it runs.
// Also forms the load/store address and passes control through to EX/MEM.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (all outputs 0)
//   stall           pipeline stall vector; bit 3 holds EX from downstream
//   aluop_i         operation code
//   alusel_i        result-source select
//   reg1_i, reg2_i  source operands (reg2_i is also store data)
//   wd_i, wreg_i    destination register and write enable
//   link_address_i  return address for JAL/JALR
//   inst_i          instruction word, source of the load/store offset
//   wd_o, wreg_o    destination and write enable, passed through
//   wdata_o         result
//   aluop_o         operation code for MEM
//   mem_addr_o      reg1_i plus sign-extended load/store offset
//   reg2_o          store data
//   stallreq        EX stall request
// -----------------------------------------------------------------------------
module ex_stage #(
  parameter int XLEN       = riscv_defs::XLEN,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall,
  input  logic [4:0]      aluop_i,
  input  logic [2:0]      alusel_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  input  logic [XLEN-1:0] link_address_i,
  input  logic [31:0]     inst_i,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [4:0]      aluop_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] reg2_o,
  output logic            stallreq
);
  import riscv_defs::*;

  localparam int SHW = $clog2(XLEN);

  // ---------------------------------------------------------------------------
  // ALU and shifter
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;

  assign shamt = reg2_i[SHW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (aluop_i)
      ALU_ADD:  alu_res = reg1_i + reg2_i;
      ALU_SUB:  alu_res = reg1_i - reg2_i;
      ALU_SLL:  alu_res = reg1_i << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (reg1_i < reg2_i)};
      ALU_XOR:  alu_res = reg1_i ^ reg2_i;
      ALU_SRL:  alu_res = reg1_i >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(reg1_i) >>> shamt);
      ALU_OR:   alu_res = reg1_i | reg2_i;
      ALU_AND:  alu_res = reg1_i & reg2_i;
      // Decode places the upper immediate on reg2.
      ALU_LUI:  alu_res = reg2_i;
      default:  alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier: both operands extended to 2*XLEN according to their
  // signedness, so one signed product covers all four variants.
  // ---------------------------------------------------------------------------
  logic                   a_sx, b_sx;
  logic signed [2*XLEN-1:0] mul_a, mul_b;
  logic [2*XLEN-1:0]      prod;
  logic [XLEN-1:0]        mul_res;

  assign a_sx    = ((aluop_i == ALU_MULH) || (aluop_i == ALU_MULHSU)) & reg1_i[XLEN-1];
  assign b_sx    = (aluop_i == ALU_MULH) & reg2_i[XLEN-1];
  assign mul_a   = {{XLEN{a_sx}}, reg1_i};
  assign mul_b   = {{XLEN{b_sx}}, reg2_i};
  assign prod    = mul_a * mul_b;
  assign mul_res = (aluop_i == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  logic            div_start;
  logic            div_signed;
  logic            div_rem_sel;
  logic [XLEN-1:0] div_res;
  logic            div_busy;

  assign div_start   = !rst && (alusel_i == SEL_DIV) && is_div_op(aluop_i);
  assign div_signed  = (aluop_i == ALU_DIV) || (aluop_i == ALU_REM);
  assign div_rem_sel = (aluop_i == ALU_REM) || (aluop_i == ALU_REMU);

  ex_div #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .signed_op_i (div_signed),
    .rem_sel_i   (div_rem_sel),
    .dividend_i  (reg1_i),
    .divisor_i   (reg2_i),
    .hold_i      (stall[3]),
    .result_o    (div_res),
    .busy_o      (div_busy)
  );

  // ---------------------------------------------------------------------------
  // Load/store address: stores carry the offset split across {[31:25],[11:7]}.
  // ---------------------------------------------------------------------------
  logic [11:0]     mem_off;
  logic [XLEN-1:0] mem_addr;

  assign mem_off  = (aluop_i == ALU_STORE) ? {inst_i[31:25], inst_i[11:7]} : inst_i[31:20];
  assign mem_addr = reg1_i + {{(XLEN-12){mem_off[11]}}, mem_off};

  // ---------------------------------------------------------------------------
  // Result mux and reset gating of all outputs
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] wdata;

  always_comb begin
    wdata = '0;
    unique case (alusel_i)
      SEL_ARITH: wdata = alu_res;
      SEL_MUL:   wdata = mul_res;
      SEL_DIV:   wdata = div_res;
      SEL_LINK:  wdata = link_address_i;
      default:   wdata = '0;
    endcase
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    aluop_o    = '0;
    mem_addr_o = '0;
    reg2_o     = '0;
    stallreq   = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = wdata;
      aluop_o    = aluop_i;
      mem_addr_o = mem_addr;
      reg2_o     = reg2_i;
      stallreq   = div_busy;
    end
  end

  // Instruction bits outside the offset fields and the stall bits belonging
  // to other stages are not needed here.
  logic unused_bits;
  assign unused_bits = ^{inst_i[19:12], inst_i[6:0], stall[5:4], stall[2:0]};

endmodule
